mem_rr_arbiter: RTL and testbench

MEM_RR_ARBITER -- requirements
Module: mem_rr_arbiter

---
 rtl/mem_rr_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// ============================================================================
//  Module      : mem_rr_arbiter
//  Description : Four-requester round-robin arbiter onto one single-outstanding
//                memory command port. Optional burst lock (keep the current
//                owner for up to BURST_LEN grants) is enabled by defining the
//                macro MEM_ARB_BURST_LOCK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_rr_arbiter #(
    parameter int BURST_LEN = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [3:0]   req_write,
    input  logic [7:0]   req_wmask,
    input  logic [127:0] req_address,
    input  logic [63:0]  req_wdata,
    output logic [3:0]   req_ack,
    output logic [15:0]  req_rdata,
    output logic         mem_request,
    output logic         mem_write,
    output logic [1:0]   mem_wmask,
    output logic [31:0]  mem_address,
    output logic [15:0]  mem_wdata,
    input  logic         mem_ack,
    input  logic [15:0]  mem_rdata,
    output logic [1:0]   grant_id,
    output logic         busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t      r_state_q,       w_state_d;
    logic [1:0]  r_grant_q,       w_grant_d;
    logic        r_mem_request_q, w_mem_request_d;
    logic        r_mem_write_q,   w_mem_write_d;
    logic [1:0]  r_mem_wmask_q,   w_mem_wmask_d;
    logic [31:0] r_mem_address_q, w_mem_address_d;
    logic [15:0] r_mem_wdata_q,   w_mem_wdata_d;
    logic        r_busy_q,        w_busy_d;

    logic [1:0]  w_rr_winner;
    logic [1:0]  w_rr_idx;
    logic [1:0]  w_winner;
    logic [3:0]  w_req_ack;

    // Out-of-range burst lengths are rejected at elaboration.
    if ((BURST_LEN < 2) || (BURST_LEN > 15)) begin : g_bad_burst_len
        $error("mem_rr_arbiter: BURST_LEN must be in 2..15");
    end

    // Scan from lowest to highest priority so the highest-priority hit wins;
    // k == 4 wraps to the previous owner, which therefore ranks last.
    always_comb begin
        w_rr_winner = r_grant_q;
        w_rr_idx    = r_grant_q;
        for (int k = 4; k >= 1; k--) begin
            w_rr_idx = r_grant_q + 2'(k);
            if (req[w_rr_idx]) begin
                w_rr_winner = w_rr_idx;
            end
        end
    end

`ifdef MEM_ARB_BURST_LOCK_EN
    localparam logic [3:0] c_BURST_LAST = 4'(BURST_LEN - 1);

    logic [3:0] r_burst_cnt_q, w_burst_cnt_d;
    logic       w_keep_owner;

    always_comb begin
        w_keep_owner  = req[r_grant_q] && (r_burst_cnt_q < c_BURST_LAST);
        w_winner      = w_keep_owner ? r_grant_q : w_rr_winner;
        w_burst_cnt_d = r_burst_cnt_q;
        if ((r_state_q == ST_IDLE) && (|req)) begin
            w_burst_cnt_d = w_keep_owner ? (r_burst_cnt_q + 4'd1) : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_burst_cnt_q <= 4'd0;
        end else begin
            r_burst_cnt_q <= w_burst_cnt_d;
        end
    end
`else
    always_comb begin
        w_winner = w_rr_winner;
    end
`endif

    always_comb begin
        w_state_d       = r_state_q;
        w_grant_d       = r_grant_q;
        w_mem_request_d = r_mem_request_q;
        w_mem_write_d   = r_mem_write_q;
        w_mem_wmask_d   = r_mem_wmask_q;
        w_mem_address_d = r_mem_address_q;
        w_mem_wdata_d   = r_mem_wdata_q;
        case (r_state_q)
            ST_IDLE: begin
                if (|req) begin
                    w_state_d       = ST_ISSUE;
                    w_mem_request_d = 1'b1;
                    w_grant_d       = w_winner;
                    w_mem_write_d   = req_write[w_winner];
                    w_mem_wmask_d   = req_wmask[{w_winner, 1'b0} +: 2];
                    w_mem_address_d = req_address[{w_winner, 5'b00000} +: 32];
                    w_mem_wdata_d   = req_wdata[{w_winner, 4'b0000} +: 16];
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    w_state_d       = ST_IDLE;
                    w_mem_request_d = 1'b0;
                end
            end
            default: begin
                w_state_d       = ST_IDLE;
                w_mem_request_d = 1'b0;
            end
        endcase
        w_busy_d = (w_state_d == ST_ISSUE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q       <= ST_IDLE;
            r_grant_q       <= 2'd3;
            r_mem_request_q <= 1'b0;
            r_mem_write_q   <= 1'b0;
            r_mem_wmask_q   <= 2'b00;
            r_mem_address_q <= 32'd0;
            r_mem_wdata_q   <= 16'd0;
            r_busy_q        <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_grant_q       <= w_grant_d;
            r_mem_request_q <= w_mem_request_d;
            r_mem_write_q   <= w_mem_write_d;
            r_mem_wmask_q   <= w_mem_wmask_d;
            r_mem_address_q <= w_mem_address_d;
            r_mem_wdata_q   <= w_mem_wdata_d;
            r_busy_q        <= w_busy_d;
        end
    end

    // Completion is routed straight through to the owner; an ack seen in IDLE is dropped.
    always_comb begin
        w_req_ack = 4'b0000;
        if (mem_ack && (r_state_q == ST_ISSUE)) begin
            w_req_ack[r_grant_q] = 1'b1;
        end
    end

    assign req_ack     = w_req_ack;
    assign req_rdata   = mem_rdata;
    assign mem_request = r_mem_request_q;
    assign mem_write   = r_mem_write_q;
    assign mem_wmask   = r_mem_wmask_q;
    assign mem_address = r_mem_address_q;
    assign mem_wdata   = r_mem_wdata_q;
    assign grant_id    = r_grant_q;
    assign busy        = r_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_rr_arbiter.sv
// ============================================================================
//  Module      : tb_mem_rr_arbiter
//  Description : Directed self-checking bench for mem_rr_arbiter; the burst
//                sequence is exercised when MEM_ARB_BURST_LOCK_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_rr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [3:0]   req_write;
    logic [7:0]   req_wmask;
    logic [127:0] req_address;
    logic [63:0]  req_wdata;
    logic [3:0]   req_ack;
    logic [15:0]  req_rdata;
    logic         mem_request;
    logic         mem_write;
    logic [1:0]   mem_wmask;
    logic [31:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic         mem_ack;
    logic [15:0]  mem_rdata;
    logic [1:0]   grant_id;
    logic         busy;

    int checks = 0;
    int errors = 0;

    mem_rr_arbiter #(.BURST_LEN(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_write   (req_write),
        .req_wmask   (req_wmask),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .req_ack     (req_ack),
        .req_rdata   (req_rdata),
        .mem_request (mem_request),
        .mem_write   (mem_write),
        .mem_wmask   (mem_wmask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete transfer: grant, optional wait states, ack, then the IDLE turnaround.
    task automatic do_xfer(input logic [1:0] id, input int delay, input bit drop, input bit disturb);
        logic [31:0] ea;
        logic [15:0] ed;
        logic [1:0]  em;
        logic        ew;
        ea = req_address[{id, 5'b00000} +: 32];
        ed = req_wdata[{id, 4'b0000} +: 16];
        em = req_wmask[{id, 1'b0} +: 2];
        ew = req_write[id];
        tick();
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("mem_request_hi", 32'(mem_request), 32'd1);
        chk("busy_hi", 32'(busy), 32'd1);
        chk("mem_address", mem_address, ea);
        chk("mem_wdata", 32'(mem_wdata), 32'(ed));
        chk("mem_wmask", 32'(mem_wmask), 32'(em));
        chk("mem_write", 32'(mem_write), 32'(ew));
        chk("req_ack_before", 32'(req_ack), 32'd0);
        for (int c = 0; c < delay; c++) begin
            if (disturb && (c == 0)) begin
                req = req | 4'b0011;
                req_address[{id, 5'b00000} +: 32] = ~ea;
                req_wdata[{id, 4'b0000} +: 16]    = ~ed;
            end
            tick();
            chk("wait_mem_request", 32'(mem_request), 32'd1);
            chk("wait_mem_address", mem_address, ea);
            chk("wait_mem_wdata", 32'(mem_wdata), 32'(ed));
            chk("wait_mem_wmask", 32'(mem_wmask), 32'(em));
            chk("wait_mem_write", 32'(mem_write), 32'(ew));
            chk("wait_grant_id", 32'(grant_id), 32'(id));
            chk("wait_req_ack", 32'(req_ack), 32'd0);
        end
        mem_rdata = 16'h5A00 + 16'(id);
        mem_ack   = 1'b1;
        #1;
        chk("req_ack_onehot", 32'(req_ack), 32'(4'b0001 << id));
        chk("req_rdata", 32'(req_rdata), 32'(16'h5A00 + 16'(id)));
        tick();
        mem_ack = 1'b0;
        if (drop) req[id] = 1'b0;
        #1;
        chk("turnaround_mem_request", 32'(mem_request), 32'd0);
        chk("turnaround_busy", 32'(busy), 32'd0);
        chk("turnaround_req_ack", 32'(req_ack), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        req         = 4'b0000;
        mem_ack     = 1'b0;
        mem_rdata   = 16'h0000;
        req_write   = 4'b1010;
        req_wmask   = {2'b10, 2'b00, 2'b11, 2'b01};
        req_address = {32'h1000_030C, 32'h1000_0208, 32'h1000_0104, 32'h1000_0000};
        req_wdata   = {16'hA333, 16'hA222, 16'hA111, 16'hA000};
        tick();
        tick();
        chk("rst_mem_request", 32'(mem_request), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_req_ack", 32'(req_ack), 32'd0);
        reset = 1'b1;
        tick();

`ifdef MEM_ARB_BURST_LOCK_EN
        begin
            logic [1:0] exp_burst [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
            req = 4'b0011;
            for (int i = 0; i < 9; i++) begin
                do_xfer(exp_burst[i], 0, 1'b0, 1'b0);
            end
            req = 4'b0000;
            tick();
        end
`else
        // All four requesting, each drops after its ack.
        req = 4'b1111;
        do_xfer(2'd0, 0, 1'b1, 1'b0);
        do_xfer(2'd1, 0, 1'b1, 1'b0);
        do_xfer(2'd2, 0, 1'b1, 1'b0);
        do_xfer(2'd3, 0, 1'b1, 1'b0);
        tick();
        chk("drained_mem_request", 32'(mem_request), 32'd0);

        // Two requesters held continuously alternate.
        req = 4'b0101;
        do_xfer(2'd0, 0, 1'b0, 1'b0);
        do_xfer(2'd2, 0, 1'b0, 1'b0);
        do_xfer(2'd0, 0, 1'b0, 1'b0);
        do_xfer(2'd2, 0, 1'b0, 1'b0);
        req = 4'b0000;
        tick();

        // Slow write from requester 2; inputs disturbed while it waits.
        req_write[2]                 = 1'b1;
        req_wmask[5:4]               = 2'b10;
        req_address[95:64]           = 32'h0400_0010;
        req_wdata[47:32]             = 16'hBEEF;
        req = 4'b0100;
        do_xfer(2'd2, 5, 1'b1, 1'b1);
        req = 4'b0000;
        tick();

        // Ack while idle is ignored.
        mem_ack = 1'b1;
        #1;
        chk("idle_ack_req_ack", 32'(req_ack), 32'd0);
        tick();
        mem_ack = 1'b0;
        chk("idle_ack_busy", 32'(busy), 32'd0);
        chk("idle_ack_mem_request", 32'(mem_request), 32'd0);
        chk("idle_ack_grant_id", 32'(grant_id), 32'd2);

        // Reset in the second ISSUE cycle of a read from requester 1.
        req_write[1]       = 1'b0;
        req_address[63:32] = 32'h2000_0040;
        req = 4'b0010;
        tick();
        chk("rd_grant_id", 32'(grant_id), 32'd1);
        chk("rd_mem_request", 32'(mem_request), 32'd1);
        chk("rd_mem_write", 32'(mem_write), 32'd0);
        tick();
        chk("rd_cycle2_mem_request", 32'(mem_request), 32'd1);
        reset = 1'b0;
        #1;
        chk("rd_reset_req_ack", 32'(req_ack), 32'd0);
        tick();
        chk("post_rst_mem_request", 32'(mem_request), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_grant_id", 32'(grant_id), 32'd3);
        chk("post_rst_req_ack", 32'(req_ack), 32'd0);
        reset = 1'b1;
        req   = 4'b0011;
        do_xfer(2'd0, 0, 1'b1, 1'b0);
        req = 4'b0000;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
